// File: rtl/hazard_forwarding_unit_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipeline_pkg;

   localparam int REG_W_DEF = 4;
   localparam int CNT_W_DEF = 16;
   localparam int PC_IDX    = 15;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'b00,
      HZ_STALL = 2'b01,
      HZ_FLUSH = 2'b10
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; slave is the hazard unit, master the pipeline.
interface hazard_forwarding_unit_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] ID_Rn, ID_Rm, ID_Rd;
   logic             ID_use_Rn, ID_use_Rm, ID_use_Rd;
   logic             ID_branch_taken;
   logic [REG_W-1:0] EX_Rd;
   logic             EX_RF_enable, EX_load_instr;
   logic [REG_W-1:0] MEM_Rd;
   logic             MEM_RF_enable;
   logic [REG_W-1:0] WB_Rd;
   logic             WB_RF_enable;

   logic [1:0]       fwd_Rn_sel, fwd_Rm_sel, fwd_Rd_sel;
   logic             PC_LE, IF_ID_LE, CU_S, IF_ID_flush;
   logic [1:0]       hz_state;
   logic [CNT_W-1:0] stall_count, flush_count;

   modport slave (
      input  ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_branch_taken,
             EX_Rd, EX_RF_enable, EX_load_instr, MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable,
      output fwd_Rn_sel, fwd_Rm_sel, fwd_Rd_sel, PC_LE, IF_ID_LE, CU_S, IF_ID_flush,
             hz_state, stall_count, flush_count
   );

   modport master (
      output ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_branch_taken,
             EX_Rd, EX_RF_enable, EX_load_instr, MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable,
      input  fwd_Rn_sel, fwd_Rm_sel, fwd_Rd_sel, PC_LE, IF_ID_LE, CU_S, IF_ID_flush,
             hz_state, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_forwarding_unit_fwd_select.sv
// Per-operand forwarding source select, priority EX > MEM > WB; R15 is never forwarded.
module fwd_select
   import pipeline_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] rx_i,
   input  logic             use_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_we_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             mem_we_i,
   input  logic [REG_W-1:0] wb_rd_i,
   input  logic             wb_we_i,
   output logic [1:0]       sel_o
);
   localparam logic [REG_W-1:0] PC_REG = REG_W'(PC_IDX);

   always_comb begin
      sel_o = FWD_RF;
      if (use_i && rx_i != PC_REG) begin
         if (ex_we_i && ex_rd_i == rx_i)
            sel_o = FWD_EX;
         else if (mem_we_i && mem_rd_i == rx_i)
            sel_o = FWD_MEM;
         else if (wb_we_i && wb_rd_i == rx_i)
            sel_o = FWD_WB;
      end
   end
endmodule

// File: rtl/hazard_forwarding_unit.sv
// Load-use stall / branch flush controller with ID-stage operand forwarding and event counters.
// state    | meaning
// HZ_RUN   | normal issue; load-use and taken branches are detected here
// HZ_STALL | one bubble cycle after a load-use stall; load result now in MEM
// HZ_FLUSH | ID holds the flushed NOP; hazards ignored for this cycle
module hazard_forwarding_unit
   import pipeline_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  R,
   hazard_forwarding_unit_if.slave hz
);
   localparam logic [REG_W-1:0] PC_REG = REG_W'(PC_IDX);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             ex_fwd_ok;
   logic             rn_hit, rm_hit, rd_hit, lu;
   logic             stall_inc, flush_inc;

   // A load's data is not available in EX, so EX only forwards non-load results.
   assign ex_fwd_ok = hz.EX_RF_enable && !hz.EX_load_instr;

   fwd_select #(.REG_W(REG_W)) u_fwd_rn (
      .rx_i(hz.ID_Rn), .use_i(hz.ID_use_Rn && !R),
      .ex_rd_i(hz.EX_Rd), .ex_we_i(ex_fwd_ok),
      .mem_rd_i(hz.MEM_Rd), .mem_we_i(hz.MEM_RF_enable),
      .wb_rd_i(hz.WB_Rd), .wb_we_i(hz.WB_RF_enable),
      .sel_o(hz.fwd_Rn_sel)
   );

   fwd_select #(.REG_W(REG_W)) u_fwd_rm (
      .rx_i(hz.ID_Rm), .use_i(hz.ID_use_Rm && !R),
      .ex_rd_i(hz.EX_Rd), .ex_we_i(ex_fwd_ok),
      .mem_rd_i(hz.MEM_Rd), .mem_we_i(hz.MEM_RF_enable),
      .wb_rd_i(hz.WB_Rd), .wb_we_i(hz.WB_RF_enable),
      .sel_o(hz.fwd_Rm_sel)
   );

   fwd_select #(.REG_W(REG_W)) u_fwd_rd (
      .rx_i(hz.ID_Rd), .use_i(hz.ID_use_Rd && !R),
      .ex_rd_i(hz.EX_Rd), .ex_we_i(ex_fwd_ok),
      .mem_rd_i(hz.MEM_Rd), .mem_we_i(hz.MEM_RF_enable),
      .wb_rd_i(hz.WB_Rd), .wb_we_i(hz.WB_RF_enable),
      .sel_o(hz.fwd_Rd_sel)
   );

   assign rn_hit = hz.ID_use_Rn && hz.ID_Rn == hz.EX_Rd && hz.ID_Rn != PC_REG;
   assign rm_hit = hz.ID_use_Rm && hz.ID_Rm == hz.EX_Rd && hz.ID_Rm != PC_REG;
   assign rd_hit = hz.ID_use_Rd && hz.ID_Rd == hz.EX_Rd && hz.ID_Rd != PC_REG;
   assign lu     = hz.EX_load_instr && hz.EX_RF_enable && (rn_hit || rm_hit || rd_hit);

   always_comb begin
      state_d         = state_q;
      hz.PC_LE        = 1'b1;
      hz.IF_ID_LE     = 1'b1;
      hz.CU_S         = 1'b0;
      hz.IF_ID_flush  = 1'b0;
      stall_inc       = 1'b0;
      flush_inc       = 1'b0;
      if (R) begin
         hz.CU_S = 1'b1;
         state_d = HZ_RUN;
      end else begin
         unique case (state_q)
            HZ_RUN: begin
               // Stall outranks the branch; the branch is taken next cycle.
               if (lu) begin
                  hz.PC_LE    = 1'b0;
                  hz.IF_ID_LE = 1'b0;
                  hz.CU_S     = 1'b1;
                  state_d     = HZ_STALL;
                  stall_inc   = 1'b1;
               end else if (hz.ID_branch_taken) begin
                  hz.IF_ID_flush = 1'b1;
                  state_d        = HZ_FLUSH;
                  flush_inc      = 1'b1;
               end
            end
            HZ_STALL: begin
               if (hz.ID_branch_taken) begin
                  hz.IF_ID_flush = 1'b1;
                  state_d        = HZ_FLUSH;
                  flush_inc      = 1'b1;
               end else begin
                  state_d = HZ_RUN;
               end
            end
            HZ_FLUSH: state_d = HZ_RUN;
            default:  state_d = HZ_RUN;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state_q     <= HZ_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.hz_state    = state_q;
   assign hz.stall_count = stall_cnt_q;
   assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_forwarding_unit;
   logic clk;
   logic R;
   logic rs;

   hazard_forwarding_unit_if #(.REG_W(4), .CNT_W(16)) h ();
   hazard_forwarding_unit_if #(.REG_W(4), .CNT_W(2))  hs ();

   hazard_forwarding_unit #(.REG_W(4), .CNT_W(16)) dut (
      .clk(clk), .R(R), .hz(h.slave)
   );

   // Narrow-counter copy so saturation is reachable in a handful of stalls.
   hazard_forwarding_unit #(.REG_W(4), .CNT_W(2)) dut_s (
      .clk(clk), .R(rs), .hz(hs.slave)
   );

   localparam logic [1:0] S_RUN = 2'b00, S_STALL = 2'b01, S_FLUSH = 2'b10;

   string       name_q[$];
   int          which_q[$];
   logic [43:0] exp_q[$];
   int          checks = 0;
   int          passes = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [43:0] ev(input logic [1:0] rn, input logic [1:0] rm,
                                      input logic [1:0] rd, input logic pc, input logic ifid,
                                      input logic cus, input logic fl, input logic [1:0] st,
                                      input logic [15:0] sc, input logic [15:0] fc);
      return {rn, rm, rd, pc, ifid, cus, fl, st, sc, fc};
   endfunction

   function automatic logic [43:0] act_main();
      return {h.fwd_Rn_sel, h.fwd_Rm_sel, h.fwd_Rd_sel, h.PC_LE, h.IF_ID_LE, h.CU_S,
              h.IF_ID_flush, h.hz_state, h.stall_count, h.flush_count};
   endfunction

   task automatic push(input string nm, input int w, input logic [43:0] e);
      name_q.push_back(nm);
      which_q.push_back(w);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      h.ID_Rn = 4'd0; h.ID_Rm = 4'd0; h.ID_Rd = 4'd0;
      h.ID_use_Rn = 1'b0; h.ID_use_Rm = 1'b0; h.ID_use_Rd = 1'b0;
      h.ID_branch_taken = 1'b0;
      h.EX_Rd = 4'd0; h.EX_RF_enable = 1'b0; h.EX_load_instr = 1'b0;
      h.MEM_Rd = 4'd0; h.MEM_RF_enable = 1'b0;
      h.WB_Rd = 4'd0; h.WB_RF_enable = 1'b0;
   endtask

   task automatic load_use();
      idle();
      h.EX_load_instr = 1'b1; h.EX_RF_enable = 1'b1; h.EX_Rd = 4'd5;
      h.ID_Rm = 4'd5; h.ID_use_Rm = 1'b1;
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   initial begin
      string       nm;
      int          w;
      logic [43:0] e, act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            nm  = name_q.pop_front();
            w   = which_q.pop_front();
            e   = exp_q.pop_front();
            act = (w == 0) ? act_main() : {40'd0, hs.hz_state, hs.stall_count};
            checks++;
            if (act === e) passes++;
            else $display("FAIL %s: got %h expected %h", nm, act, e);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not reach its summary (%0d/%0d)", passes, checks);
      $fatal(1);
   end

   initial begin
      logic [3:0] sat_exp [9];
      sat_exp = '{4'h0, 4'h5, 4'h1, 4'h6, 4'h2, 4'h7, 4'h3, 4'h7, 4'h3};

      R = 1'b1;
      rs = 1'b1;
      idle();
      hs.ID_Rn = 4'd0; hs.ID_Rm = 4'd5; hs.ID_Rd = 4'd0;
      hs.ID_use_Rn = 1'b0; hs.ID_use_Rm = 1'b1; hs.ID_use_Rd = 1'b0;
      hs.ID_branch_taken = 1'b0;
      hs.EX_Rd = 4'd5; hs.EX_RF_enable = 1'b1; hs.EX_load_instr = 1'b1;
      hs.MEM_Rd = 4'd0; hs.MEM_RF_enable = 1'b0;
      hs.WB_Rd = 4'd0; hs.WB_RF_enable = 1'b0;

      // Reset must override a forwarding match and a taken branch.
      h.ID_Rn = 4'd3; h.ID_use_Rn = 1'b1; h.EX_Rd = 4'd3; h.EX_RF_enable = 1'b1;
      h.ID_branch_taken = 1'b1;
      #1;
      push("reset_hold", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 1, 0, S_RUN, 16'd0, 16'd0));
      @(posedge clk);
      @(posedge clk);
      #1;
      R = 1'b0;
      idle();
      push("reset_release", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();

      idle();
      h.ID_Rn = 4'd3; h.ID_use_Rn = 1'b1;
      h.EX_Rd = 4'd3; h.EX_RF_enable = 1'b1;
      h.MEM_Rd = 4'd3; h.MEM_RF_enable = 1'b1;
      h.WB_Rd = 4'd3; h.WB_RF_enable = 1'b1;
      push("fwd_ex_prio", 0, ev(2'b01, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();
      h.EX_RF_enable = 1'b0;
      push("fwd_mem_prio", 0, ev(2'b10, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();
      h.MEM_RF_enable = 1'b0;
      push("fwd_wb", 0, ev(2'b11, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();
      h.EX_RF_enable = 1'b1; h.MEM_RF_enable = 1'b1; h.ID_use_Rn = 1'b0;
      push("fwd_unused", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();
      h.ID_use_Rn = 1'b1; h.ID_Rn = 4'd15;
      h.EX_Rd = 4'd15; h.MEM_Rd = 4'd15; h.WB_Rd = 4'd15;
      push("fwd_r15", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();

      idle();
      h.ID_Rn = 4'd1; h.ID_use_Rn = 1'b1;
      h.ID_Rm = 4'd2; h.ID_use_Rm = 1'b1;
      h.ID_Rd = 4'd4; h.ID_use_Rd = 1'b1;
      h.EX_Rd = 4'd1; h.EX_RF_enable = 1'b1;
      h.MEM_Rd = 4'd2; h.MEM_RF_enable = 1'b1;
      h.WB_Rd = 4'd4; h.WB_RF_enable = 1'b1;
      push("fwd_per_operand", 0, ev(2'b01, 2'b10, 2'b11, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();

      load_use();
      push("lu_stall", 0, ev(2'd0, 2'd0, 2'd0, 0, 0, 1, 0, S_RUN, 16'd0, 16'd0));
      tick();
      // EX hazard left visible on purpose: STALL must mask it.
      h.MEM_Rd = 4'd5; h.MEM_RF_enable = 1'b1;
      push("lu_stall_release", 0, ev(2'd0, 2'b10, 2'd0, 1, 1, 0, 0, S_STALL, 16'd1, 16'd0));
      tick();
      idle();
      push("lu_back_run", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd1, 16'd0));
      tick();

      idle();
      h.ID_branch_taken = 1'b1;
      push("br_flush", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 1, S_RUN, 16'd1, 16'd0));
      tick();
      load_use();
      h.ID_branch_taken = 1'b1;
      push("flush_ignore", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_FLUSH, 16'd1, 16'd1));
      tick();
      push("simul_stall", 0, ev(2'd0, 2'd0, 2'd0, 0, 0, 1, 0, S_RUN, 16'd1, 16'd1));
      tick();
      h.EX_load_instr = 1'b0; h.EX_RF_enable = 1'b0; h.EX_Rd = 4'd0;
      h.MEM_Rd = 4'd5; h.MEM_RF_enable = 1'b1;
      push("simul_flush", 0, ev(2'd0, 2'b10, 2'd0, 1, 1, 0, 1, S_STALL, 16'd2, 16'd1));
      tick();
      idle();
      push("simul_flush_state", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_FLUSH, 16'd2, 16'd2));
      tick();
      push("after_simul", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd2, 16'd2));
      tick();

      load_use();
      push("pre_reset_stall", 0, ev(2'd0, 2'd0, 2'd0, 0, 0, 1, 0, S_RUN, 16'd2, 16'd2));
      tick();
      // Now in STALL with counters 3/2; reset lands mid-cycle, no edge before the sample.
      R = 1'b1;
      push("async_reset_stall", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 1, 0, S_RUN, 16'd0, 16'd0));
      tick();
      R = 1'b0;
      idle();
      push("reset_release2", 0, ev(2'd0, 2'd0, 2'd0, 1, 1, 0, 0, S_RUN, 16'd0, 16'd0));
      tick();

      rs = 1'b0;
      for (int i = 0; i < 9; i++) begin
         push($sformatf("sat_step%0d", i), 1, {40'd0, sat_exp[i]});
         tick();
      end

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
         checks += exp_q.size();
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
